bp_lce_mem_port_arbiter: RTL and testbench
==========================================

// Module: bp_lce_mem_port_arbiter
// PURPOSE
// - Shares one cache memory port (data, tag or stat mem) between the cache pipeline and the LCE command engine.
// - Instantiated once per memory. Sits between the cache/LCE and the SRAM wrapper.
// - The cache has default priority. A starvation timer forces the cache off the port so a blocked LCE is granted.
// - It also tags each accepted read so the 1-cycle read data is steered back to the winning requester.
// PARAMETERS
// - pkt_width_p          "inv"  width of the memory packet (tag/data/stat mem pkt)
// - data_width_p         "inv"  width of the read data returned by the memory
// - timeout_max_limit_p  4      consecutive blocked LCE cycles before a forced LCE grant
// - cooldown_p           1      cycles the cache keeps priority after a forced grant; range 1..7
// PORTS
// - clk_i             in   1             clock, rising edge
// - reset_n_i         in   1             asynchronous, active-low reset
// - cache_pkt_i       in   pkt_width_p   cache packet
// - cache_rd_i        in   1             cache packet is a read
// - cache_v_i         in   1             cache valid; ready->valid handshake
// - cache_ready_o     out  1             port available to the cache this cycle
// - cache_busy_o      out  1             tells the cache to stop issuing new requests; feeds the LCE busy OR
// - lce_pkt_i         in   pkt_width_p   LCE packet
// - lce_rd_i          in   1             LCE packet is a read
// - lce_v_i           in   1             LCE valid; valid->yumi handshake
// - lce_yumi_o        out  1             LCE packet consumed this cycle
// - mem_pkt_o         out  pkt_width_p   packet to the memory
// - mem_v_o           out  1             memory access valid
// - mem_ready_i       in   1             memory can accept this cycle
// - mem_data_i        in   data_width_p  read data, valid 1 cycle after an accepted read
// - cache_data_o      out  data_width_p  read data to the cache
// - cache_data_v_o    out  1             cache read data valid
// - lce_data_o        out  data_width_p  read data to the LCE
// - lce_data_v_o      out  1             LCE read data valid
// BEHAVIOUR
// - Reset values: all outputs 0, state=e_normal, counters 0, rd_owner_r=0, rd_pend_r=0.
// - Reset is asynchronous. Asserting it mid-operation drops any pending read return: no data_v is raised for it.
// - States:
//   - e_normal: cache_ready_o = mem_ready_i.
//     - Cache accepted when cache_v_i & cache_ready_o.
//     - lce_yumi_o = lce_v_i & mem_ready_i & ~cache_v_i.
//   - e_starve: cache_ready_o=0, cache_busy_o=1, lce_yumi_o = lce_v_i & mem_ready_i.
//   - e_cooldown: same as e_normal. The starvation counter is held at 0.
// - Transitions:
//   - e_normal -> e_starve when blocked_cnt_r == timeout_max_limit_p.
//     - "Blocked" means lce_v_i & ~lce_yumi_o. Otherwise the counter clears; it saturates at the limit.
//   - e_starve -> e_cooldown on lce_yumi_o. The cooldown counter loads cooldown_p.
//   - e_starve -> e_normal if lce_v_i drops without a yumi (no forced grant needed).
//   - e_cooldown -> e_normal when the cooldown counter reaches 0.
// - cache_busy_o is also 1 in e_normal in the cycle blocked_cnt_r == timeout_max_limit_p-1 and lce_v_i=1.
//   - This gives the cache one cycle of warning.
// - Mux: mem_v_o = cache accept | lce_yumi_o; mem_pkt_o selects the winner. The two never both win.
// - Read return:
//   - On an accepted read, rd_pend_r<=1 and rd_owner_r<=winner (0=cache, 1=lce). Otherwise rd_pend_r<=0.
//   - Next cycle, {cache,lce}_data_v_o = rd_pend_r & owner match. Data ports are a combinational copy of mem_data_i.
// - Boundaries:
//   - mem_ready_i=0 -> no grant, no yumi. The starvation counter still counts if lce_v_i=1.
//   - Simultaneous valids in e_normal -> cache wins.
//   - Simultaneous valids in e_starve -> LCE wins.
//   - A back-to-back read from the other requester the very next cycle is legal; the owner updates each cycle.
// CONFIGURATION
// - BP_LCE_MEM_ARB_STATS_EN defined:
//   - Adds outputs stat_cache_grants_o[31:0], stat_lce_grants_o[31:0] and stat_starve_events_o[15:0].
//   - All are saturating, reset to 0. starve_events increments on each e_normal->e_starve.
// - Undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.
// STRUCTURE
// - Shared package (bp_me_pkg): typedef enum logic [1:0] {e_normal, e_starve, e_cooldown} bp_lce_mem_arb_state_e.
// - Package also holds the owner encoding constants (e_arb_owner_cache=0, e_arb_owner_lce=1).
// - Sub-module: the starvation timer is a bsg_counter_clear_up (max_val_p=timeout_max_limit_p).
//   - clear_i = ~blocked | state!=e_normal; up_i = blocked & state==e_normal.
// - Cooldown counter, FSM and return-tag flops are inline.
// TESTING
// - Cache only: cache_v_i=1 for 10 cycles, mem_ready_i=1 -> 10 grants. lce_yumi_o=0, cache_busy_o=0.
// - LCE only: lce read, pkt=0x5A -> yumi same cycle. Next cycle lce_data_v_o=1, lce_data_o=mem_data_i, cache_data_v_o=0.
// - Starvation, limit=4: cache_v_i & lce_v_i held.
//   - cache_busy_o=1 at cycle 3; cycle 4 e_starve and lce_yumi_o=1.
//   - Next cooldown_p cycles the cache is granted.
// - Interleaved reads: cache rd at t, LCE rd at t+1 -> cache_data_v_o at t+1, lce_data_v_o at t+2, never both.
// - mem_ready_i=0 for 6 cycles with both valid -> no grants. State reaches e_starve; first ready cycle grants the LCE.
// - Reset: assert reset_n_i=0 the cycle after an accepted read -> no data_v next cycle; all outputs 0 asynchronously.

Source files
------------

// File: rtl/bp_lce_mem_port_arbiter_pkg.sv
// Shared types for the LCE/cache memory port arbiter: FSM state encoding
// and the read-return owner tag values.
package bp_me_pkg;

    typedef enum logic [1:0] {
        e_normal   = 2'd0,
        e_starve   = 2'd1,
        e_cooldown = 2'd2
    } bp_lce_mem_arb_state_e;

    // Owner tag stored with each accepted read so the return is steered back.
    localparam logic e_arb_owner_cache = 1'b0;
    localparam logic e_arb_owner_lce   = 1'b1;

    // Width of the cooldown down-counter; cooldown lengths are 1..7 cycles.
    localparam int unsigned arb_cool_width_gp = 3;

endpackage

// File: rtl/bp_lce_mem_port_arbiter_bsg_counter_clear_up.sv
// Saturating up-counter with synchronous clear. Used as the LCE starvation
// timer: counts consecutive blocked cycles and holds at max_val_p.
module bsg_counter_clear_up #(
    parameter int max_val_p = 4,
    parameter int width_p   = $clog2(max_val_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

    logic [width_p-1:0] count_q;
    logic [width_p-1:0] count_d;

    // Next count: clear wins, otherwise increment until the saturation value.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (up_i && (count_q != max_lp)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bp_lce_mem_port_arbiter.sv
// Arbitrates one cache memory port between the cache pipeline (default
// priority, ready->valid) and the LCE command engine (valid->yumi). A
// starvation timer forces the port to the LCE after a run of blocked cycles,
// followed by a short cooldown that gives the cache priority back.
// Accepted reads are tagged so the 1-cycle read return goes to its owner.
//
// Handshakes: the cache transfers when cache_v_i & cache_ready_o in the same
// cycle; the LCE presents lce_v_i and is consumed when lce_yumi_o is high.
// Both imply mem_v_o with mem_ready_i high; at most one wins per cycle.
//
// Optional build macro BP_LCE_MEM_ARB_STATS_EN adds saturating grant and
// starvation-event counters; arbitration is unchanged either way.
//
// dbg_state_o exposes the FSM state for observation.
module bp_lce_mem_port_arbiter
    import bp_me_pkg::*;
#(
    parameter int pkt_width_p         = 16,
    parameter int data_width_p        = 32,
    parameter int timeout_max_limit_p = 4,
    parameter int cooldown_p          = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [pkt_width_p-1:0]  cache_pkt_i,
    input  logic                    cache_rd_i,
    input  logic                    cache_v_i,
    output logic                    cache_ready_o,
    output logic                    cache_busy_o,
    input  logic [pkt_width_p-1:0]  lce_pkt_i,
    input  logic                    lce_rd_i,
    input  logic                    lce_v_i,
    output logic                    lce_yumi_o,
    output logic [pkt_width_p-1:0]  mem_pkt_o,
    output logic                    mem_v_o,
    input  logic                    mem_ready_i,
    input  logic [data_width_p-1:0] mem_data_i,
    output logic [data_width_p-1:0] cache_data_o,
    output logic                    cache_data_v_o,
    output logic [data_width_p-1:0] lce_data_o,
    output logic                    lce_data_v_o,
    output logic [1:0]              dbg_state_o
`ifdef BP_LCE_MEM_ARB_STATS_EN
   ,output logic [31:0]             stat_cache_grants_o
   ,output logic [31:0]             stat_lce_grants_o
   ,output logic [15:0]             stat_starve_events_o
`endif
);

    localparam int cnt_w_lp = $clog2(timeout_max_limit_p + 1);
    localparam logic [cnt_w_lp-1:0] limit_lp = cnt_w_lp'(timeout_max_limit_p);
    localparam logic [cnt_w_lp-1:0] warn_lp  = cnt_w_lp'(timeout_max_limit_p - 1);
    localparam logic [arb_cool_width_gp-1:0] cool_load_lp = arb_cool_width_gp'(cooldown_p);

    bp_lce_mem_arb_state_e state_q, state_d;
    logic [arb_cool_width_gp-1:0] cool_q, cool_d;
    logic rd_pend_q, rd_pend_d;
    logic rd_owner_q, rd_owner_d;

    logic [cnt_w_lp-1:0] blocked_cnt;
    logic cache_ready, cache_busy, lce_yumi, cache_acc, blocked, in_normal;

    // Handshake decode: the cache owns the port unless the FSM is forcing the LCE.
    always_comb begin
        cache_ready = 1'b0;
        cache_busy  = 1'b0;
        lce_yumi    = 1'b0;
        in_normal   = (state_q == e_normal);
        if (state_q == e_starve) begin
            cache_busy = 1'b1;
            lce_yumi   = lce_v_i & mem_ready_i;
        end else begin
            cache_ready = mem_ready_i;
            lce_yumi    = lce_v_i & mem_ready_i & ~cache_v_i;
            // One-cycle warning before the forced grant.
            cache_busy  = in_normal & lce_v_i & (blocked_cnt == warn_lp);
        end
        cache_acc = cache_v_i & cache_ready;
        blocked   = lce_v_i & ~lce_yumi;
    end

    bsg_counter_clear_up #(
        .max_val_p (timeout_max_limit_p),
        .width_p   (cnt_w_lp)
    ) starve_timer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (~blocked | ~in_normal),
        .up_i      (blocked & in_normal),
        .count_o   (blocked_cnt)
    );

    // Next state. Starvation takes effect in the cycle the timer reads the
    // limit, so the edge that loads the limit also enters e_starve.
    always_comb begin
        state_d = state_q;
        cool_d  = cool_q;
        case (state_q)
            e_normal: begin
                if ((blocked && (blocked_cnt == warn_lp)) || (blocked_cnt == limit_lp)) begin
                    state_d = e_starve;
                end
            end
            e_starve: begin
                if (lce_yumi) begin
                    state_d = e_cooldown;
                    cool_d  = cool_load_lp;
                end else if (!lce_v_i) begin
                    state_d = e_normal;
                end
            end
            e_cooldown: begin
                if (cool_q <= 1) begin
                    state_d = e_normal;
                    cool_d  = '0;
                end else begin
                    cool_d  = cool_q - 1'b1;
                end
            end
            default: begin
                state_d = e_normal;
                cool_d  = '0;
            end
        endcase
    end

    // Read-return tag: remember whether this cycle's winner issued a read.
    always_comb begin
        rd_pend_d  = (cache_acc & cache_rd_i) | (lce_yumi & lce_rd_i);
        rd_owner_d = rd_owner_q;
        if (rd_pend_d) begin
            rd_owner_d = lce_yumi ? e_arb_owner_lce : e_arb_owner_cache;
        end
    end

    // FSM, cooldown and read-tag registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_normal;
            cool_q     <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= e_arb_owner_cache;
        end else begin
            state_q    <= state_d;
            cool_q     <= cool_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Outputs are forced low while reset is asserted, independent of the clock.
    always_comb begin
        cache_ready_o  = reset_n_i & cache_ready;
        cache_busy_o   = reset_n_i & cache_busy;
        lce_yumi_o     = reset_n_i & lce_yumi;
        mem_v_o        = reset_n_i & (cache_acc | lce_yumi);
        mem_pkt_o      = '0;
        if (reset_n_i && lce_yumi) begin
            mem_pkt_o = lce_pkt_i;
        end else if (reset_n_i && cache_acc) begin
            mem_pkt_o = cache_pkt_i;
        end
        cache_data_o   = reset_n_i ? mem_data_i : '0;
        lce_data_o     = reset_n_i ? mem_data_i : '0;
        cache_data_v_o = reset_n_i & rd_pend_q & (rd_owner_q == e_arb_owner_cache);
        lce_data_v_o   = reset_n_i & rd_pend_q & (rd_owner_q == e_arb_owner_lce);
        dbg_state_o    = state_q;
    end

`ifdef BP_LCE_MEM_ARB_STATS_EN
    logic [31:0] stat_cache_q, stat_lce_q;
    logic [15:0] stat_starve_q;

    // Saturating grant and starvation-event counters.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stat_cache_q  <= '0;
            stat_lce_q    <= '0;
            stat_starve_q <= '0;
        end else begin
            if (cache_acc && (stat_cache_q != '1)) stat_cache_q <= stat_cache_q + 1'b1;
            if (lce_yumi && (stat_lce_q != '1)) stat_lce_q <= stat_lce_q + 1'b1;
            if (in_normal && (state_d == e_starve) && (stat_starve_q != '1)) begin
                stat_starve_q <= stat_starve_q + 1'b1;
            end
        end
    end

    assign stat_cache_grants_o  = stat_cache_q;
    assign stat_lce_grants_o    = stat_lce_q;
    assign stat_starve_events_o = stat_starve_q;
`endif

endmodule

// File: tb/tb_bp_lce_mem_port_arbiter.sv
// Self-checking bench for bp_lce_mem_port_arbiter: directed scenarios plus
// random traffic, a cycle-level reference model, and a scoreboard monitor.
module tb_bp_lce_mem_port_arbiter;
    import bp_me_pkg::*;

    localparam int PKT_W  = 16;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 4;
    localparam int COOL   = 2;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    logic reset_n_i;

    logic [PKT_W-1:0]  cache_pkt_i, lce_pkt_i, mem_pkt_o;
    logic              cache_rd_i, cache_v_i, cache_ready_o, cache_busy_o;
    logic              lce_rd_i, lce_v_i, lce_yumi_o;
    logic              mem_v_o, mem_ready_i;
    logic [DATA_W-1:0] mem_data_i, cache_data_o, lce_data_o;
    logic              cache_data_v_o, lce_data_v_o;
    logic [1:0]        dbg_state_o;
`ifdef BP_LCE_MEM_ARB_STATS_EN
    logic [31:0] stat_cache_grants_o, stat_lce_grants_o;
    logic [15:0] stat_starve_events_o;
`endif

    bp_lce_mem_port_arbiter #(
        .pkt_width_p(PKT_W), .data_width_p(DATA_W),
        .timeout_max_limit_p(LIMIT), .cooldown_p(COOL)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cache_pkt_i(cache_pkt_i), .cache_rd_i(cache_rd_i), .cache_v_i(cache_v_i),
        .cache_ready_o(cache_ready_o), .cache_busy_o(cache_busy_o),
        .lce_pkt_i(lce_pkt_i), .lce_rd_i(lce_rd_i), .lce_v_i(lce_v_i), .lce_yumi_o(lce_yumi_o),
        .mem_pkt_o(mem_pkt_o), .mem_v_o(mem_v_o), .mem_ready_i(mem_ready_i),
        .mem_data_i(mem_data_i),
        .cache_data_o(cache_data_o), .cache_data_v_o(cache_data_v_o),
        .lce_data_o(lce_data_o), .lce_data_v_o(lce_data_v_o),
        .dbg_state_o(dbg_state_o)
`ifdef BP_LCE_MEM_ARB_STATS_EN
       ,.stat_cache_grants_o(stat_cache_grants_o)
       ,.stat_lce_grants_o(stat_lce_grants_o)
       ,.stat_starve_events_o(stat_starve_events_o)
`endif
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [5:0]        exp_hs_q[$];   // {state, cache_ready, busy, yumi, mem_v}
    logic [PKT_W-1:0]  exp_mem_q[$];  // granted packets in order
    logic [DATA_W:0]   exp_ret_q[$];  // {owner, data} due this cycle
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Expressed as: consecutive blocked LCE cycles, a "forcing" flag, and the
    // number of cooldown cycles left.
    bit m_forcing;
    int m_cool;
    int m_run;
    bit ret_staged;
    bit ret_owner;

    task automatic model_reset();
        m_forcing  = 1'b0;
        m_cool     = 0;
        m_run      = 0;
        ret_staged = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit cv, input bit crd, input bit lv, input bit lrd, input bit rdy,
                         input logic [PKT_W-1:0] cpkt, input logic [PKT_W-1:0] lpkt);
        bit e_cr, e_busy, e_yumi, e_cg;
        bp_lce_mem_arb_state_e e_state;
        @(posedge clk_i); #1;
        cache_pkt_i = cpkt;
        lce_pkt_i   = lpkt;
        mem_data_i  = $urandom;
        if (ret_staged) begin
            exp_ret_q.push_back({ret_owner, mem_data_i});
            ret_staged = 1'b0;
        end
        cache_v_i = cv; cache_rd_i = crd; lce_v_i = lv; lce_rd_i = lrd; mem_ready_i = rdy;

        e_state = m_forcing ? e_starve : ((m_cool > 0) ? e_cooldown : e_normal);
        if (m_forcing) begin
            e_cr = 1'b0; e_busy = 1'b1; e_yumi = lv & rdy;
        end else begin
            e_cr   = rdy;
            e_yumi = lv & rdy & ~cv;
            e_busy = (m_cool == 0) && lv && (m_run == LIMIT - 1);
        end
        e_cg = cv & e_cr;
        exp_hs_q.push_back({e_state, e_cr, e_busy, e_yumi, e_cg | e_yumi});
        if (e_cg) begin
            exp_mem_q.push_back(cpkt);
            if (crd) begin ret_staged = 1'b1; ret_owner = 1'b0; end
        end
        if (e_yumi) begin
            exp_mem_q.push_back(lpkt);
            if (lrd) begin ret_staged = 1'b1; ret_owner = 1'b1; end
        end

        if (m_forcing) begin
            if (e_yumi) begin m_forcing = 1'b0; m_cool = COOL; end
            else if (!lv) m_forcing = 1'b0;
            m_run = 0;
        end else if (m_cool > 0) begin
            m_cool--;
            m_run = 0;
        end else if (lv && !e_yumi) begin
            m_run++;
            if (m_run == LIMIT) begin m_forcing = 1'b1; m_run = 0; end
        end else begin
            m_run = 0;
        end
        mon_en = 1'b1;
    endtask

    task automatic drive_rand(input int pc, input int pl, input int pr);
        drive($urandom_range(0, 99) < pc, $urandom_range(0, 1) == 1,
              $urandom_range(0, 99) < pl, $urandom_range(0, 1) == 1,
              $urandom_range(0, 99) < pr, PKT_W'($urandom), PKT_W'($urandom));
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_hs"}, {cache_ready_o, cache_busy_o, lce_yumi_o, mem_v_o,
                              cache_data_v_o, lce_data_v_o, dbg_state_o}, 0);
        check({name, "_pkt"}, mem_pkt_o, 0);
        check({name, "_data"}, {cache_data_o, lce_data_o}, 0);
    endtask

    // ---------------- monitor ----------------
    logic [5:0]      mon_hs;
    logic [DATA_W:0] mon_ret;
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (exp_hs_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL hs_underflow got=empty exp=entry at %0t", $time);
            end else begin
                mon_hs = exp_hs_q.pop_front();
                check("handshake", {dbg_state_o, cache_ready_o, cache_busy_o, lce_yumi_o, mem_v_o}, mon_hs);
            end
            if (mem_v_o) begin
                if (exp_mem_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_pkt_unexpected got=%0h exp=none at %0t", mem_pkt_o, $time);
                end else begin
                    check("mem_pkt", mem_pkt_o, exp_mem_q.pop_front());
                end
            end
            check("ret_exclusive", cache_data_v_o & lce_data_v_o, 0);
            check("ret_valid", cache_data_v_o | lce_data_v_o, exp_ret_q.size() != 0);
            if (exp_ret_q.size() != 0) begin
                mon_ret = exp_ret_q.pop_front();
                if (cache_data_v_o | lce_data_v_o) begin
                    check("ret_owner", lce_data_v_o, mon_ret[DATA_W]);
                    check("ret_data", lce_data_v_o ? lce_data_o : cache_data_o, mon_ret[DATA_W-1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n_i = 1'b0;
        cache_pkt_i = '0; lce_pkt_i = '0; mem_data_i = '0;
        cache_rd_i = 0; cache_v_i = 0; lce_rd_i = 0; lce_v_i = 0; mem_ready_i = 0;
        model_reset();

        // Reset state: outputs held low even with active inputs.
        repeat (2) @(posedge clk_i);
        #1;
        cache_v_i = 1; lce_v_i = 1; mem_ready_i = 1; cache_rd_i = 1;
        cache_pkt_i = 16'h1234; lce_pkt_i = 16'h5678; mem_data_i = 32'hDEAD_BEEF;
        #1 check_outputs_zero("reset_init");
        @(posedge clk_i); #1;
        cache_v_i = 0; lce_v_i = 0; mem_ready_i = 0; cache_rd_i = 0;
        reset_n_i = 1'b1;

        // Cache only, 10 cycles.
        for (int i = 0; i < 10; i++) drive(1, $urandom_range(0, 1) == 1, 0, 0, 1, PKT_W'($urandom), '0);
        // LCE only read of 0x5A, then return cycle.
        drive(0, 0, 1, 1, 1, '0, 16'h005A);
        drive(0, 0, 0, 0, 1, '0, '0);
        // Starvation with both valid and memory ready.
        for (int i = 0; i < 12; i++) drive(1, 1, 1, 1, 1, PKT_W'($urandom), PKT_W'($urandom));
        repeat (3) drive(0, 0, 0, 0, 1, '0, '0);
        // Enter starvation, then LCE withdraws before being granted.
        for (int i = 0; i < 4; i++) drive(1, 0, 1, 0, 1, PKT_W'($urandom), PKT_W'($urandom));
        drive(1, 0, 1, 0, 0, PKT_W'($urandom), PKT_W'($urandom));
        drive(1, 0, 0, 0, 1, PKT_W'($urandom), '0);
        repeat (2) drive(0, 0, 0, 0, 1, '0, '0);
        // Interleaved reads: cache then LCE back to back.
        drive(1, 1, 0, 0, 1, PKT_W'($urandom), '0);
        drive(0, 0, 1, 1, 1, '0, PKT_W'($urandom));
        drive(0, 0, 0, 0, 1, '0, '0);
        // Memory not ready for 6 cycles with both valid, then ready.
        for (int i = 0; i < 6; i++) drive(1, 1, 1, 1, 0, PKT_W'($urandom), PKT_W'($urandom));
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 1, 1, PKT_W'($urandom), PKT_W'($urandom));
        repeat (2) drive(0, 0, 0, 0, 1, '0, '0);
        // Random traffic, heavy LCE contention.
        for (int i = 0; i < 500; i++) drive_rand(60, 60, 80);

        // Reset the cycle after an accepted read.
        drive(1, 1, 0, 0, 1, PKT_W'($urandom), '0);
        @(posedge clk_i); #1;
        mon_en = 1'b0;
        reset_n_i = 1'b0;
        cache_v_i = 1; lce_v_i = 1; mem_ready_i = 1; mem_data_i = 32'hA5A5_5A5A;
        #1 check_outputs_zero("reset_mid");
        model_reset();
        exp_ret_q.delete();
        @(negedge clk_i);
        check("reset_no_ret", {cache_data_v_o, lce_data_v_o}, 0);
        @(posedge clk_i); #1;
        cache_v_i = 0; lce_v_i = 0; mem_ready_i = 0;
        reset_n_i = 1'b1;

        for (int i = 0; i < 150; i++) drive_rand(50, 50, 70);
        repeat (2) drive(0, 0, 0, 0, 1, '0, '0);
        @(negedge clk_i); #1;
        mon_en = 1'b0;

        check("end_hs_q_empty", exp_hs_q.size(), 0);
        check("end_mem_q_empty", exp_mem_q.size(), 0);
        check("end_ret_q_empty", exp_ret_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
